// File: rtl/channel_rr_arbiter_if.sv
// Channel interfaces shared by the round-robin arbiter and its neighbours.
// channel_if carries one data/valid/ack stream; channel_array_if packs M of
// them side by side. The master drives data and valid, the slave drives ack.

interface channel_if #(
    parameter int N = 8
);
    logic [N-1:0] d;
    logic         v;
    logic         a;

    modport master (output d, output v, input  a);
    modport slave  (input  d, input  v, output a);
endinterface

interface channel_array_if #(
    parameter int N = 8,
    parameter int M = 4
);
    logic [M-1:0][N-1:0] d;
    logic [M-1:0]        v;
    logic [M-1:0]        a;

    modport master (output d, output v, input  a);
    modport slave  (input  d, input  v, output a);
endinterface

// File: rtl/channel_rr_arbiter.sv
// Round-robin arbiter sharing one output channel among M requesters, with an
// optional burst lock of up to MaxBurst back-to-back transfers per grant.
// Once a requester is offered on the output it stays selected until it
// transfers, so out.d is stable under backpressure.

module channel_rr_arbiter #(
    parameter int N        = -1,
    parameter int M        = 4,
    parameter int MaxBurst = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    channel_array_if.slave       in,
    channel_if.master            out,
    output logic [$clog2(M)-1:0] owner
);
    localparam int IW = $clog2(M);

    if (N < 1) begin : g_bad_n
        $error("channel_rr_arbiter: N must be set to a positive width");
    end
    if (M < 2 || M > 16) begin : g_bad_m
        $error("channel_rr_arbiter: M must be in 2..16");
    end
    if (MaxBurst < 1 || MaxBurst > 255) begin : g_bad_burst
        $error("channel_rr_arbiter: MaxBurst must be in 1..255");
    end

    typedef enum logic {IDLE, LOCK} state_t;

    state_t        state, state_next;
    logic [IW-1:0] own, own_next;
    logic [IW-1:0] last, last_next;
    logic [7:0]    cnt, cnt_next;

    logic [IW-1:0] base, cand, rr, sel;
    logic          found, eff_idle, valid, xfer;
    logic [M-1:0]  grant;

    // Round-robin candidate: first valid input after base, wrapping modulo M.
    // In LOCK with the owner gone, the scan starts after the owner itself so
    // the handover happens in the same cycle.
    always_comb begin
        base  = (state == LOCK) ? own : last;
        rr    = base;
        cand  = base;
        found = 1'b0;
        for (int unsigned k = 1; k <= M; k++) begin
            cand = IW'((32'(base) + k) % M);
            if (!found && in.v[cand]) begin
                rr    = cand;
                found = 1'b1;
            end
        end
    end

    // Selection and handshake: hold the owner while it stays valid in LOCK.
    always_comb begin
        eff_idle = (state == IDLE) || !in.v[own];
        sel      = eff_idle ? rr : own;
        valid    = !reset && (eff_idle ? (|in.v) : in.v[own]);
        xfer     = valid && out.a;
        grant    = '0;
        if (xfer) begin
            grant[sel] = 1'b1;
        end
    end

    assign out.v = valid;
    assign out.d = in.d[sel];
    assign in.a  = grant;
    assign owner = sel;

    // Next-state: grant, burst counting, hold under stall, early release.
    always_comb begin
        state_next = state;
        own_next   = own;
        last_next  = last;
        cnt_next   = cnt;
        if (eff_idle) begin
            if (valid) begin
                if (xfer && MaxBurst == 1) begin
                    state_next = IDLE;
                    last_next  = sel;
                    cnt_next   = '0;
                end else if (xfer) begin
                    state_next = LOCK;
                    own_next   = sel;
                    cnt_next   = 8'd1;
                end else begin
                    state_next = LOCK;
                    own_next   = sel;
                    cnt_next   = '0;
                end
            end else begin
                state_next = IDLE;
                if (state == LOCK) begin
                    last_next = own;
                    cnt_next  = '0;
                end
            end
        end else if (xfer) begin
            if (({1'b0, cnt} + 9'd1) == 9'(MaxBurst)) begin
                state_next = IDLE;
                last_next  = own;
                cnt_next   = '0;
            end else begin
                cnt_next = cnt + 8'd1;
            end
        end
    end

    // State registers with synchronous reset; input 0 gets first priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            own   <= '0;
            last  <= IW'(M - 1);
            cnt   <= '0;
        end else begin
            state <= state_next;
            own   <= own_next;
            last  <= last_next;
            cnt   <= cnt_next;
        end
    end

    // An offered requester must not withdraw before its first transfer.
    assert property (@(posedge clk) disable iff (reset)
        !(state == LOCK && !in.v[own] && cnt == 8'd0))
        else $error("channel_rr_arbiter: owner dropped valid before first transfer");

endmodule

// File: tb/tb_channel_rr_arbiter.sv
// Scoreboard bench for channel_rr_arbiter: three instances (MaxBurst 1, 3, 4)
// driven by directed vectors; expected transfers are queued per instance and
// a negedge monitor pops and compares every completed transfer.

module tb_channel_rr_arbiter;
    localparam int N = 8;
    localparam int M = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [M-1:0]        v  [3];
    logic [M-1:0][N-1:0] d  [3];
    logic                a  [3];
    logic [M-1:0]        ia [3];
    logic                ov [3];
    logic [N-1:0]        od [3];
    logic [1:0]          ow [3];

    typedef struct packed {
        logic [1:0] own;
        logic [7:0] dat;
    } exp_t;

    exp_t q [3][$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   seq4 [7] = '{1, 2, 2, 2, 3, 3, 3};
    int   seq6 [5] = '{0, 0, 0, 0, 1};

    for (genvar k = 0; k < 3; k++) begin : g
        localparam int MB = (k == 0) ? 1 : ((k == 1) ? 3 : 4);
        channel_array_if #(.N(N), .M(M)) ch_in ();
        channel_if #(.N(N)) ch_out ();
        assign ch_in.v  = v[k];
        assign ch_in.d  = d[k];
        assign ch_out.a = a[k];
        assign ia[k]    = ch_in.a;
        assign ov[k]    = ch_out.v;
        assign od[k]    = ch_out.d;
        channel_rr_arbiter #(.N(N), .M(M), .MaxBurst(MB)) dut (
            .clk   (clk),
            .reset (reset),
            .in    (ch_in),
            .out   (ch_out),
            .owner (ow[k])
        );
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(int k, int o, logic [7:0] dat);
        exp_t e;
        e.own = 2'(o);
        e.dat = dat;
        q[k].push_back(e);
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        for (int k = 0; k < 3; k++) begin
            v[k] = '0;
            a[k] = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_all();
        tick(2);
        reset = 1'b0;
    endtask

    task automatic drain(string name);
        tick(2);
        for (int k = 0; k < 3; k++) begin
            chk(name, q[k].size(), 0);
        end
    endtask

    // Monitor: every completed transfer must match the head of its queue.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!reset && ov[k] === 1'b1 && a[k] === 1'b1) begin
                n_chk++;
                if (q[k].size() == 0) begin
                    n_fail++;
                    $display("FAIL xfer_unexpected inst%0d: got owner=%0d data=%0h, expected no transfer",
                             k, ow[k], od[k]);
                end else begin
                    exp_t e;
                    e = q[k].pop_front();
                    if (ow[k] !== e.own || od[k] !== e.dat || ia[k] !== (4'b0001 << e.own)) begin
                        n_fail++;
                        $display("FAIL xfer inst%0d: got owner=%0d data=%0h ack=%b, expected owner=%0d data=%0h",
                                 k, ow[k], od[k], ia[k], e.own, e.dat);
                    end
                end
            end else begin
                chk("idle_in_a", 32'(ia[k]), 0);
            end
        end
    end

    initial begin
        reset = 1'b1;
        idle_all();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < M; i++) begin
                d[k][i] = 8'hA0 + 8'(i);
            end
        end

        // 1: reset for 3 cycles gates outputs, then a single transfer from input 2
        v[1] = '1;
        v[2] = '1;
        for (int k = 0; k < 3; k++) a[k] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                chk("reset_out_v", 32'(ov[k]), 0);
                chk("reset_in_a", 32'(ia[k]), 0);
            end
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        idle_all();
        a[0]    = 1'b1;
        v[0]    = 4'b0100;
        d[0][2] = 8'h05;
        push(0, 2, 8'h05);
        tick(1);
        v[0]    = '0;
        d[0][2] = 8'hA2;
        drain("t1_drain");

        // 2: plain round-robin, all valid, always ack
        do_reset();
        v[0] = '1;
        a[0] = 1'b1;
        for (int t = 0; t < 6; t++) push(0, t % 4, 8'hA0 + 8'(t % 4));
        tick(6);
        idle_all();
        drain("t2_drain");

        // 3: bursts of three per grant
        do_reset();
        v[1] = '1;
        a[1] = 1'b1;
        for (int t = 0; t < 9; t++) push(1, t / 3, 8'hA0 + 8'(t / 3));
        tick(9);
        idle_all();
        drain("t3_drain");

        // 4: input 1 releases after one word, handover to 2 with no bubble
        do_reset();
        v[1] = 4'b1110;
        a[1] = 1'b1;
        for (int t = 0; t < 7; t++) push(1, seq4[t], 8'hA0 + 8'(seq4[t]));
        tick(1);
        v[1] = 4'b1100;
        tick(6);
        idle_all();
        drain("t4_drain");

        // 5: stall with input 3 offered; input 0 rising mid-stall has no effect
        do_reset();
        v[0] = 4'b1000;
        a[0] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) v[0] = 4'b1001;
            @(negedge clk);
            chk("stall_valid", 32'(ov[0]), 1);
            chk("stall_owner", 32'(ow[0]), 3);
            chk("stall_data", 32'(od[0]), 32'hA3);
            @(posedge clk);
            #1;
        end
        push(0, 3, 8'hA3);
        push(0, 0, 8'hA0);
        a[0] = 1'b1;
        tick(1);
        v[0] = 4'b0001;
        tick(1);
        idle_all();
        drain("t5_drain");

        // 6: reset after two words of a four-word burst from input 1
        do_reset();
        v[2] = 4'b0010;
        a[2] = 1'b1;
        push(2, 1, 8'hA1);
        push(2, 1, 8'hA1);
        tick(2);
        reset = 1'b1;
        v[2]  = 4'b0011;
        @(negedge clk);
        chk("midreset_out_v", 32'(ov[2]), 0);
        chk("midreset_in_a", 32'(ia[2]), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int t = 0; t < 5; t++) push(2, seq6[t], 8'hA0 + 8'(seq6[t]));
        tick(5);
        idle_all();
        drain("t6_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
